// File: rtl/riscv_multicycle_ctrl_if.sv
// Control-unit bus: IR/flag/memory-ready inputs and all datapath control outputs.
// The master modport belongs to the controller; the slave modport belongs to the datapath side.
interface riscv_multicycle_ctrl_if;
    logic [31:0] instr;
    logic        zero;
    logic        mem_ready;
    logic        mem_req;
    logic        mem_we;
    logic        iord;
    logic        ir_write;
    logic        pc_write;
    logic        pc_src;
    logic        reg_write;
    logic [1:0]  wb_sel;
    logic [1:0]  alu_src_a;
    logic [1:0]  alu_src_b;
    logic [3:0]  aluop;
    logic        illegal;
    logic [3:0]  state;

    modport master (
        input  instr, zero, mem_ready,
        output mem_req, mem_we, iord, ir_write, pc_write, pc_src, reg_write,
               wb_sel, alu_src_a, alu_src_b, aluop, illegal, state
    );

    modport slave (
        output instr, zero, mem_ready,
        input  mem_req, mem_we, iord, ir_write, pc_write, pc_src, reg_write,
               wb_sel, alu_src_a, alu_src_b, aluop, illegal, state
    );
endinterface

// File: rtl/riscv_multicycle_ctrl.sv
// Multi-cycle RV32I control FSM: decodes the IR and sequences fetch, execute,
// memory and write-back, issuing ALU codes and a req/ready memory handshake.
module riscv_multicycle_ctrl (
    input  logic                          clk,
    input  logic                          rst,
    riscv_multicycle_ctrl_if.master       bus
);
    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_EXEC_R   = 4'd2;
    localparam logic [3:0] S_EXEC_I   = 4'd3;
    localparam logic [3:0] S_ALU_WB   = 4'd4;
    localparam logic [3:0] S_MEM_ADDR = 4'd5;
    localparam logic [3:0] S_MEM_RD   = 4'd6;
    localparam logic [3:0] S_LOAD_WB  = 4'd7;
    localparam logic [3:0] S_MEM_WR   = 4'd8;
    localparam logic [3:0] S_BRANCH   = 4'd9;
    localparam logic [3:0] S_JAL      = 4'd10;
    localparam logic [3:0] S_ILLEGAL  = 4'd11;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    logic [3:0] state_q, state_d;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       f7b5;
    logic [3:0] r_code, i_code;
    logic       unused_instr;

    assign opcode = bus.instr[6:0];
    assign funct3 = bus.instr[14:12];
    assign f7b5   = bus.instr[30];
    assign r_code = {f7b5, funct3};
    // Only shifts take funct7[5] in I-type; otherwise it is immediate data (addi must stay add).
    assign i_code = {(funct3 == 3'b101) ? f7b5 : 1'b0, funct3};
    assign unused_instr = ^{bus.instr[31], bus.instr[29:15], bus.instr[11:7]};

    logic       mem_req_c, mem_we_c, iord_c, ir_write_c, pc_write_c, pc_src_c;
    logic       reg_write_c, illegal_c;
    logic [1:0] wb_sel_c, src_a_c, src_b_c;
    logic [3:0] aluop_c;

    always_comb begin
        state_d     = state_q;
        mem_req_c   = 1'b0;
        mem_we_c    = 1'b0;
        iord_c      = 1'b0;
        ir_write_c  = 1'b0;
        pc_write_c  = 1'b0;
        pc_src_c    = 1'b0;
        reg_write_c = 1'b0;
        illegal_c   = 1'b0;
        wb_sel_c    = 2'b00;
        src_a_c     = 2'b00;
        src_b_c     = 2'b00;
        aluop_c     = 4'b0000;
        case (state_q)
            S_FETCH: begin
                mem_req_c = 1'b1;
                src_b_c   = 2'b01;
                if (bus.mem_ready) begin
                    ir_write_c = 1'b1;
                    pc_write_c = 1'b1;
                    state_d    = S_DECODE;
                end
            end
            S_DECODE: begin
                src_a_c = 2'b10;
                src_b_c = 2'b10;
                case (opcode)
                    OP_R:         state_d = S_EXEC_R;
                    OP_I:         state_d = S_EXEC_I;
                    OP_LW, OP_SW: state_d = S_MEM_ADDR;
                    OP_BR:        state_d = (funct3 == 3'b000 || funct3 == 3'b001) ? S_BRANCH : S_ILLEGAL;
                    OP_JAL:       state_d = S_JAL;
                    default:      state_d = S_ILLEGAL;
                endcase
            end
            S_EXEC_R: begin
                src_a_c = 2'b01;
                aluop_c = r_code;
                state_d = S_ALU_WB;
            end
            S_EXEC_I: begin
                src_a_c = 2'b01;
                src_b_c = 2'b10;
                aluop_c = i_code;
                state_d = S_ALU_WB;
            end
            S_ALU_WB: begin
                reg_write_c = 1'b1;
                state_d     = S_FETCH;
            end
            S_MEM_ADDR: begin
                src_a_c = 2'b01;
                src_b_c = 2'b10;
                state_d = opcode[5] ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
                mem_req_c = 1'b1;
                iord_c    = 1'b1;
                if (bus.mem_ready) state_d = S_LOAD_WB;
            end
            S_LOAD_WB: begin
                reg_write_c = 1'b1;
                wb_sel_c    = 2'b01;
                state_d     = S_FETCH;
            end
            S_MEM_WR: begin
                mem_req_c = 1'b1;
                mem_we_c  = 1'b1;
                iord_c    = 1'b1;
                if (bus.mem_ready) state_d = S_FETCH;
            end
            S_BRANCH: begin
                src_a_c    = 2'b01;
                aluop_c    = 4'b1000;
                pc_src_c   = 1'b1;
                pc_write_c = (funct3 == 3'b000 && bus.zero) || (funct3 == 3'b001 && !bus.zero);
                state_d    = S_FETCH;
            end
            S_JAL: begin
                reg_write_c = 1'b1;
                wb_sel_c    = 2'b10;
                pc_write_c  = 1'b1;
                pc_src_c    = 1'b1;
                state_d     = S_FETCH;
            end
            S_ILLEGAL: begin
                illegal_c = 1'b1;
            end
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_FETCH;
        else     state_q <= state_d;
    end

    // Strobes are masked while rst is high so an abandoned access never leaks a pulse.
    assign bus.mem_req   = mem_req_c   & ~rst;
    assign bus.mem_we    = mem_we_c    & ~rst;
    assign bus.ir_write  = ir_write_c  & ~rst;
    assign bus.pc_write  = pc_write_c  & ~rst;
    assign bus.reg_write = reg_write_c & ~rst;
    assign bus.illegal   = illegal_c   & ~rst;
    assign bus.iord      = iord_c;
    assign bus.pc_src    = pc_src_c;
    assign bus.wb_sel    = wb_sel_c;
    assign bus.alu_src_a = src_a_c;
    assign bus.alu_src_b = src_b_c;
    assign bus.aluop     = aluop_c;
    assign bus.state     = state_q;
endmodule

// File: tb/tb_riscv_multicycle_ctrl.sv
// Directed bench for riscv_multicycle_ctrl: per-feature tasks with hand-computed expectations.
module tb_riscv_multicycle_ctrl;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    riscv_multicycle_ctrl_if bus();
    riscv_multicycle_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

    int total = 0;
    int bad   = 0;

    localparam logic [31:0] I_ADD  = 32'h002081B3;
    localparam logic [31:0] I_LW   = 32'h0000A283;
    localparam logic [31:0] I_SW   = 32'h0020A023;
    localparam logic [31:0] I_JAL  = 32'h008000EF;
    localparam logic [31:0] I_BEQ  = 32'h00208463;
    localparam logic [31:0] I_BNE  = 32'h00209463;
    localparam logic [31:0] I_LUI  = 32'h000012B7;
    localparam logic [31:0] I_BBAD = 32'h0020A463;

    // Advance one clock; observation point is 1 time unit after the falling edge.
    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; bus.instr = 32'h0; bus.zero = 1'b0; bus.mem_ready = 1'b1;
        cyc();
        total++;
        if ({bus.state, bus.mem_req, bus.mem_we, bus.ir_write, bus.pc_write, bus.reg_write, bus.illegal} !== 10'b0000_000000) begin
            bad++; $display("FAIL reset_strobes got=%b want=%b", {bus.state, bus.mem_req, bus.mem_we, bus.ir_write, bus.pc_write, bus.reg_write, bus.illegal}, 10'b0);
        end
        total++;
        if ({bus.iord, bus.alu_src_a, bus.alu_src_b, bus.aluop, bus.pc_src} !== 10'b0_00_01_0000_0) begin
            bad++; $display("FAIL reset_selects got=%b want=%b", {bus.iord, bus.alu_src_a, bus.alu_src_b, bus.aluop, bus.pc_src}, 10'b0_00_01_0000_0);
        end
        rst = 1'b0; #1;
        total++;
        if ({bus.state, bus.mem_req, bus.iord, bus.ir_write, bus.pc_write} !== {4'd0, 4'b1011}) begin
            bad++; $display("FAIL reset_release got=%b want=%b", {bus.state, bus.mem_req, bus.iord, bus.ir_write, bus.pc_write}, {4'd0, 4'b1011});
        end
        $display("reset: total=%0d bad=%0d", total, bad);
    endtask

    task automatic test_add();
        bus.instr = I_ADD; bus.mem_ready = 1'b1;
        total++;
        if ({bus.state, bus.mem_req, bus.iord, bus.ir_write, bus.pc_write, bus.pc_src, bus.alu_src_a, bus.alu_src_b, bus.aluop} !== {4'd0, 5'b10110, 2'b00, 2'b01, 4'b0000}) begin
            bad++; $display("FAIL add_fetch got=%b", {bus.state, bus.mem_req, bus.iord, bus.ir_write, bus.pc_write, bus.pc_src, bus.alu_src_a, bus.alu_src_b, bus.aluop});
        end
        cyc();
        total++;
        if ({bus.state, bus.alu_src_a, bus.alu_src_b, bus.aluop, bus.reg_write, bus.mem_req} !== {4'd1, 2'b10, 2'b10, 4'b0000, 2'b00}) begin
            bad++; $display("FAIL add_decode got=%b", {bus.state, bus.alu_src_a, bus.alu_src_b, bus.aluop, bus.reg_write, bus.mem_req});
        end
        cyc();
        total++;
        if ({bus.state, bus.alu_src_a, bus.alu_src_b, bus.aluop, bus.reg_write} !== {4'd2, 2'b01, 2'b00, 4'b0000, 1'b0}) begin
            bad++; $display("FAIL add_exec got=%b", {bus.state, bus.alu_src_a, bus.alu_src_b, bus.aluop, bus.reg_write});
        end
        cyc();
        total++;
        if ({bus.state, bus.reg_write, bus.wb_sel} !== {4'd4, 1'b1, 2'b00}) begin
            bad++; $display("FAIL add_wb got=%b want=%b", {bus.state, bus.reg_write, bus.wb_sel}, {4'd4, 3'b100});
        end
        cyc();
        total++;
        if ({bus.state, bus.reg_write} !== {4'd0, 1'b0}) begin
            bad++; $display("FAIL add_return got=%b want=%b", {bus.state, bus.reg_write}, 5'b0);
        end
        $display("add: total=%0d bad=%0d", total, bad);
    endtask

    task automatic test_alu_codes();
        logic [31:0] vi [6] = '{32'h402081B3, 32'h0020C1B3, 32'h4020D1B3, 32'h4020D093, 32'h0020D093, 32'h40008093};
        logic [3:0]  vs [6] = '{4'd2, 4'd2, 4'd2, 4'd3, 4'd3, 4'd3};
        logic [1:0]  vb [6] = '{2'b00, 2'b00, 2'b00, 2'b10, 2'b10, 2'b10};
        logic [3:0]  vo [6] = '{4'b1000, 4'b0100, 4'b1101, 4'b1101, 4'b0101, 4'b0000};
        for (int i = 0; i < 6; i++) begin
            bus.instr = vi[i];
            cyc(); cyc();
            total++;
            if ({bus.state, bus.alu_src_a, bus.alu_src_b, bus.aluop} !== {vs[i], 2'b01, vb[i], vo[i]}) begin
                bad++; $display("FAIL alu_code[%0d] instr=%h got=%b want=%b", i, vi[i], {bus.state, bus.alu_src_a, bus.alu_src_b, bus.aluop}, {vs[i], 2'b01, vb[i], vo[i]});
            end
            cyc(); cyc();
            $display("alu_code instr=%h aluop=%b", vi[i], vo[i]);
        end
    endtask

    task automatic test_fetch_wait_jal();
        int n = 0;
        bus.instr = I_JAL; bus.mem_ready = 1'b0; #1;
        for (int i = 0; i < 2; i++) begin
            total++;
            if ({bus.state, bus.mem_req, bus.iord, bus.ir_write, bus.pc_write} !== {4'd0, 4'b1000}) begin
                bad++; $display("FAIL fetch_wait[%0d] got=%b want=%b", i, {bus.state, bus.mem_req, bus.iord, bus.ir_write, bus.pc_write}, {4'd0, 4'b1000});
            end
            cyc(); n++;
        end
        bus.mem_ready = 1'b1; #1;
        total++;
        if ({bus.state, bus.mem_req, bus.ir_write, bus.pc_write} !== {4'd0, 3'b111}) begin
            bad++; $display("FAIL fetch_ready got=%b want=%b", {bus.state, bus.mem_req, bus.ir_write, bus.pc_write}, {4'd0, 3'b111});
        end
        cyc(); cyc(); n += 2;
        total++;
        if ({bus.state, bus.reg_write, bus.wb_sel, bus.pc_write, bus.pc_src, bus.mem_req} !== {4'd10, 6'b110110}) begin
            bad++; $display("FAIL jal got=%b want=%b", {bus.state, bus.reg_write, bus.wb_sel, bus.pc_write, bus.pc_src, bus.mem_req}, {4'd10, 6'b110110});
        end
        cyc(); n++;
        total++;
        if (bus.state !== 4'd0 || n !== 5) begin
            bad++; $display("FAIL jal_cycles state=%0d cycles=%0d want state=0 cycles=5", bus.state, n);
        end
        $display("fetch_wait+jal: cycles=%0d", n);
    endtask

    task automatic test_lw_wait();
        int n = 0;
        bus.instr = I_LW; bus.mem_ready = 1'b1;
        cyc(); n++;
        cyc(); n++;
        total++;
        if ({bus.state, bus.alu_src_a, bus.alu_src_b, bus.aluop, bus.mem_req} !== {4'd5, 2'b01, 2'b10, 4'b0000, 1'b0}) begin
            bad++; $display("FAIL lw_addr got=%b", {bus.state, bus.alu_src_a, bus.alu_src_b, bus.aluop, bus.mem_req});
        end
        bus.mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc(); n++;
            if (i == 3) begin bus.mem_ready = 1'b1; #1; end
            total++;
            if ({bus.state, bus.mem_req, bus.iord, bus.mem_we, bus.reg_write} !== {4'd6, 4'b1100}) begin
                bad++; $display("FAIL lw_rd[%0d] got=%b want=%b", i, {bus.state, bus.mem_req, bus.iord, bus.mem_we, bus.reg_write}, {4'd6, 4'b1100});
            end
        end
        cyc(); n++;
        total++;
        if ({bus.state, bus.reg_write, bus.wb_sel, bus.mem_req} !== {4'd7, 4'b1010}) begin
            bad++; $display("FAIL lw_wb got=%b want=%b", {bus.state, bus.reg_write, bus.wb_sel, bus.mem_req}, {4'd7, 4'b1010});
        end
        cyc(); n++;
        total++;
        if (bus.state !== 4'd0 || n !== 8) begin
            bad++; $display("FAIL lw_cycles state=%0d cycles=%0d want state=0 cycles=8", bus.state, n);
        end
        $display("lw_wait: cycles=%0d", n);
    endtask

    task automatic test_branch();
        logic [31:0] bi [4] = '{I_BEQ, I_BEQ, I_BNE, I_BNE};
        logic        bz [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        logic        bp [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) begin
            bus.instr = bi[i]; bus.mem_ready = 1'b1;
            cyc(); cyc();
            bus.zero = bz[i]; #1;
            total++;
            if ({bus.state, bus.pc_write, bus.pc_src, bus.alu_src_a, bus.alu_src_b, bus.aluop} !== {4'd9, bp[i], 1'b1, 2'b01, 2'b00, 4'b1000}) begin
                bad++; $display("FAIL branch[%0d] got=%b want=%b", i, {bus.state, bus.pc_write, bus.pc_src, bus.alu_src_a, bus.alu_src_b, bus.aluop}, {4'd9, bp[i], 1'b1, 2'b01, 2'b00, 4'b1000});
            end
            cyc();
            total++;
            if (bus.state !== 4'd0) begin
                bad++; $display("FAIL branch_return[%0d] state=%0d want=0", i, bus.state);
            end
            $display("branch instr=%h zero=%b pc_write=%b", bi[i], bz[i], bp[i]);
        end
        bus.zero = 1'b0;
    endtask

    task automatic test_back_to_back();
        bus.instr = I_SW; bus.mem_ready = 1'b1;
        cyc(); cyc(); cyc();
        total++;
        if ({bus.state, bus.mem_req, bus.mem_we, bus.iord, bus.reg_write} !== {4'd8, 4'b1110}) begin
            bad++; $display("FAIL sw_wr got=%b want=%b", {bus.state, bus.mem_req, bus.mem_we, bus.iord, bus.reg_write}, {4'd8, 4'b1110});
        end
        bus.instr = I_ADD;
        cyc();
        total++;
        if ({bus.state, bus.mem_req, bus.mem_we, bus.iord, bus.ir_write} !== {4'd0, 4'b1001}) begin
            bad++; $display("FAIL sw_next_fetch got=%b want=%b", {bus.state, bus.mem_req, bus.mem_we, bus.iord, bus.ir_write}, {4'd0, 4'b1001});
        end
        cyc(); cyc();
        total++;
        if ({bus.state, bus.aluop} !== {4'd2, 4'b0000}) begin
            bad++; $display("FAIL b2b_add_exec got=%b want=%b", {bus.state, bus.aluop}, {4'd2, 4'b0000});
        end
        cyc(); cyc();
        $display("back_to_back: sw then add done");
    endtask

    task automatic test_mem_wr_reset();
        bus.instr = I_SW; bus.mem_ready = 1'b1;
        cyc(); cyc();
        bus.mem_ready = 1'b0;
        cyc(); cyc();
        total++;
        if ({bus.state, bus.mem_req, bus.mem_we, bus.iord} !== {4'd8, 3'b111}) begin
            bad++; $display("FAIL wr_wait got=%b want=%b", {bus.state, bus.mem_req, bus.mem_we, bus.iord}, {4'd8, 3'b111});
        end
        rst = 1'b1; #1;
        total++;
        if ({bus.state, bus.mem_req, bus.mem_we, bus.ir_write, bus.pc_write} !== {4'd0, 4'b0000}) begin
            bad++; $display("FAIL wr_rst got=%b want=%b", {bus.state, bus.mem_req, bus.mem_we, bus.ir_write, bus.pc_write}, 8'b0);
        end
        cyc();
        rst = 1'b0; bus.mem_ready = 1'b1; #1;
        total++;
        if ({bus.state, bus.mem_req, bus.iord, bus.mem_we} !== {4'd0, 3'b100}) begin
            bad++; $display("FAIL wr_rst_release got=%b want=%b", {bus.state, bus.mem_req, bus.iord, bus.mem_we}, {4'd0, 3'b100});
        end
        $display("mem_wr_reset: recovered");
    endtask

    task automatic test_illegal();
        logic [31:0] li [2] = '{I_LUI, I_BBAD};
        for (int i = 0; i < 2; i++) begin
            bus.instr = li[i]; bus.mem_ready = 1'b1;
            cyc();
            cyc();
            total++;
            if ({bus.state, bus.illegal, bus.mem_req} !== {4'd11, 2'b10}) begin
                bad++; $display("FAIL illegal_enter[%0d] got=%b want=%b", i, {bus.state, bus.illegal, bus.mem_req}, {4'd11, 2'b10});
            end
            cyc(); cyc();
            total++;
            if ({bus.state, bus.illegal, bus.mem_req, bus.reg_write, bus.pc_write} !== {4'd11, 4'b1000}) begin
                bad++; $display("FAIL illegal_sticky[%0d] got=%b want=%b", i, {bus.state, bus.illegal, bus.mem_req, bus.reg_write, bus.pc_write}, {4'd11, 4'b1000});
            end
            rst = 1'b1; #1;
            total++;
            if ({bus.state, bus.illegal, bus.mem_req} !== {4'd0, 2'b00}) begin
                bad++; $display("FAIL illegal_rst[%0d] got=%b want=%b", i, {bus.state, bus.illegal, bus.mem_req}, 6'b0);
            end
            cyc();
            rst = 1'b0; #1;
            total++;
            if ({bus.state, bus.mem_req, bus.iord, bus.illegal} !== {4'd0, 3'b100}) begin
                bad++; $display("FAIL illegal_resume[%0d] got=%b want=%b", i, {bus.state, bus.mem_req, bus.iord, bus.illegal}, {4'd0, 3'b100});
            end
            $display("illegal instr=%h handled", li[i]);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_add();
        test_alu_codes();
        test_fetch_wait_jal();
        test_lw_wait();
        test_branch();
        test_back_to_back();
        test_mem_wr_reset();
        test_illegal();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/riscv_multicycle_ctrl.md
# riscv_multicycle_ctrl

Multi-cycle control unit for the RV32I datapath. Decodes the instruction register and sequences the datapath over several cycles. Issues the 4-bit ALU operation code consumed by the datapath ALU and a memory request/ready handshake for instruction and data accesses. Sits between the IR/memory port and the register file, PC, and ALU muxes.

## Interface
- No parameters; datapath width fixed at 32.
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- instr  in  32  current IR contents (opcode [6:0], funct3 [14:12], funct7[5] = bit 30)
- zero  in  1  ALU zero flag, same cycle
- mem_ready  in  1  memory completes the pending request this cycle
- mem_req  out  1  memory request; held until mem_ready
- mem_we  out  1  write qualifier for mem_req
- iord  out  1  address select: 0 = PC, 1 = ALUOut register
- ir_write  out  1  load IR from memory read data
- pc_write  out  1  load PC
- pc_src  out  1  PC source: 0 = ALU result, 1 = ALUOut register
- reg_write  out  1  register-file write enable
- wb_sel  out  2  write-back source: 00 = ALUOut, 01 = MDR, 10 = PC
- alu_src_a  out  2  00 = PC, 01 = rs1, 10 = oldPC
- alu_src_b  out  2  00 = rs2, 01 = constant 4, 10 = immediate
- aluop  out  4  ALU operation code (see Operation)
- illegal  out  1  sticky unsupported-opcode flag
- state  out  4  current state, for debug

## Operation
- ALU code map:
  - 0000 add, 0001 sll, 0010 slt, 0011 sltu, 0100 xor
  - 0101 srl, 0110 or, 0111 and, 1000 sub, 1101 sra
- Code derivation:
  - R-type: aluop = {funct7[5], funct3}.
  - I-ALU: aluop = {funct3==101 ? funct7[5] : 0, funct3}. addi never maps to sub.
- Supported opcodes:
  - 0110011 R, 0010011 I-ALU, 0000011 lw, 0100011 sw
  - 1100011 beq/bne, 1101111 jal
  - Anything else, including branch funct3 other than 000/001, goes to ILLEGAL.
- Defaults in every state: all strobes 0, selects 00, aluop 0000.
- States and transitions:
  - FETCH: mem_req=1, iord=0, a=00, b=01, add. On mem_ready: ir_write=1, pc_write=1, pc_src=0, then DECODE. Otherwise stay.
  - DECODE: a=10, b=10, add (branch/jump target into ALUOut). Then by opcode: EXEC_R, EXEC_I, MEM_ADDR, BRANCH, JAL or ILLEGAL.
  - EXEC_R: a=01, b=00, R-type code. Then ALU_WB.
  - EXEC_I: a=01, b=10, I-ALU code. Then ALU_WB.
  - ALU_WB: reg_write=1, wb_sel=00. Then FETCH.
  - MEM_ADDR: a=01, b=10, add. Then MEM_RD for lw, MEM_WR for sw.
  - MEM_RD: mem_req=1, iord=1. Wait for mem_ready, then LOAD_WB.
  - LOAD_WB: reg_write=1, wb_sel=01. Then FETCH.
  - MEM_WR: mem_req=1, mem_we=1, iord=1. Wait for mem_ready, then FETCH.
  - BRANCH: a=01, b=00, aluop=1000, pc_src=1. pc_write = (funct3==000 & zero) | (funct3==001 & !zero). Then FETCH.
  - JAL: reg_write=1, wb_sel=10 (PC already holds PC+4), pc_write=1, pc_src=1. Then FETCH.
  - ILLEGAL: illegal=1, all strobes 0. Stays here until rst.
- mem_ready is ignored in states with mem_req=0.

## Timing
- Reset behaviour:
  - rst asserted: state=FETCH immediately.
  - While rst is high, mem_req, mem_we, ir_write, pc_write and reg_write are forced to 0, and illegal=0.
  - Selects take FETCH values.
- Reset mid-operation (including during a memory wait): the operation is abandoned. There is no strobe in the cycle rst is high. FETCH issues on the first clock after release.
- Outputs are combinational from state plus instr/zero/mem_ready. State is registered on the rising edge.
- Cycles per instruction with zero-wait memory (mem_ready high in the request cycle):
  - R/I: 4
  - lw: 5
  - sw: 4
  - beq/bne: 3
  - jal: 3
- Each wait cycle adds 1 in FETCH/MEM_RD/MEM_WR.
- mem_req stays high and iord/mem_we stay stable from assertion through the mem_ready cycle inclusive.
- ir_write and pc_write pulse exactly once per fetch, in the mem_ready cycle.
- instr must be stable from DECODE until the return to FETCH. The IR changes only on ir_write.

## Test plan
- add x3,x1,x2 (0x002081B3), mem_ready tied high:
  - Expected states: FETCH, DECODE, EXEC_R, ALU_WB.
  - aluop=0000 in EXEC_R; reg_write=1 only in cycle 4.
- sub (funct7[5]=1) gives aluop=1000. srai (0x4020D093) gives aluop=1101. srli gives 0101. addi with bit30=1 gives 0000.
- lw with mem_ready low for 3 cycles in MEM_RD:
  - mem_req=1, iord=1 held for 4 cycles; then LOAD_WB with wb_sel=01.
  - Total 8 cycles.
- beq with zero=1: pc_write=1, pc_src=1 in BRANCH. With zero=0: pc_write=0. bne: inverted.
- Opcode 0110111 (lui): enters ILLEGAL after DECODE, illegal=1, no further mem_req. rst clears it and FETCH resumes.
- rst asserted during a MEM_WR wait: mem_req drops the same cycle; after release, FETCH asserts mem_req with iord=0.
